// File: rtl/riscv_pkg.sv
// Shared data-memory definitions: access-size encoding and byte-lane enable constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/riscv_dmem_lane_gen.sv
// Combinational lane decode: byte enables, lane-replicated store data and misalignment
// for one data-memory access.
module riscv_dmem_lane_gen
    import riscv_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned
);

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        be         = BE_NONE;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            MEM_BYTE: begin
                be        = BE_BYTE0 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_HALF: begin
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            MEM_WORD: begin
                be         = BE_WORD;
                misaligned = |addr_lo;
            end
            default: ;  // illegal size is reported by the top level
        endcase
    end

endmodule

// File: rtl/riscv_dmem.sv
// Single-port synchronous data memory with registered reads and sticky error capture.
// Optional legal-access counters are built when RISCV_DMEM_STATS_EN is defined.
module riscv_dmem
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    input  logic        dmem_wen_i,
    input  logic        dmem_ren_i,
    input  logic [1:0]  dmem_size_i,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i
`ifdef RISCV_DMEM_STATS_EN
    ,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic             misaligned;
    logic             shape_err;
    logic             access_err;
    logic             do_write;
    logic             legal_load;
    logic             legal_store;
    mem_size_e        size;

    assign size     = mem_size_e'(dmem_size_i);
    assign offset   = dmem_addr_i - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign word_idx = offset[IDX_W+1:2];

    riscv_dmem_lane_gen u_lane_gen (
        .addr_lo    (dmem_addr_i[1:0]),
        .size       (size),
        .wdata      (dmem_wdata_i),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .misaligned (misaligned)
    );

    // A simultaneous load+store is an error but the store still commits if well formed.
    assign shape_err   = misaligned | ~in_range | (size == MEM_ILLEGAL);
    assign access_err  = (dmem_wen_i | dmem_ren_i) & (shape_err | (dmem_wen_i & dmem_ren_i));
    assign do_write    = dmem_wen_i & ~shape_err;
    assign legal_load  = dmem_ren_i & ~access_err;
    assign legal_store = dmem_wen_i & ~access_err;

    // NOTE: the storage array has no reset; clearing it would prevent RAM inference.
    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dmem_rdata_o <= '0;
        end else if (dmem_ren_i) begin
            dmem_rdata_o <= access_err ? '0 : mem[word_idx];
        end
    end

    // A new error in the clear cycle wins over the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (access_err && (!err_o || err_clr_i)) begin
            err_o      <= 1'b1;
            err_addr_o <= dmem_addr_i;
        end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end
    end

`ifdef RISCV_DMEM_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else if (err_clr_i) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            rd_count_o <= rd_count_o + 32'(legal_load);
            wr_count_o <= wr_count_o + 32'(legal_store);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = legal_load ^ legal_store;
`endif

endmodule

// File: tb/tb_riscv_dmem.sv
// Self-checking bench for riscv_dmem: byte-addressed reference model compared every
// falling edge, plus directed literal checks.
module tb_riscv_dmem;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam int unsigned SPAN        = DEPTH_WORDS * 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [31:0] dmem_rdata_o;
    logic        dmem_wen_i;
    logic        dmem_ren_i;
    logic [1:0]  dmem_size_i;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i;
`ifdef RISCV_DMEM_STATS_EN
    logic [31:0] rd_count_o;
    logic [31:0] wr_count_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    riscv_dmem #(.DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_wen_i   (dmem_wen_i),
        .dmem_ren_i   (dmem_ren_i),
        .dmem_size_i  (dmem_size_i),
        .err_o        (err_o),
        .err_addr_o   (err_addr_o),
        .err_clr_i    (err_clr_i)
`ifdef RISCV_DMEM_STATS_EN
        ,
        .rd_count_o   (rd_count_o),
        .wr_count_o   (wr_count_o)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        else
            n_pass++;
    endtask

    // Reference model: byte-addressed storage and the access rules applied per edge.
    logic [7:0]  m_mem [SPAN];
    logic [31:0] e_rdata, e_err_addr, e_rd, e_wr;
    logic        e_err;

    initial begin
        for (int i = 0; i < int'(SPAN); i++) m_mem[i] = 'x;
    end

    always @(posedge clock or negedge reset_n) begin : model
        logic [31:0] off;
        int          nbytes;
        bit          shape_bad, bad;
        if (!reset_n) begin
            e_rdata <= '0; e_err <= 1'b0; e_err_addr <= '0; e_rd <= '0; e_wr <= '0;
        end else begin
            off    = dmem_addr_i - BASE_ADDR;
            nbytes = (dmem_size_i == 2'd0) ? 1 : (dmem_size_i == 2'd1) ? 2 : 4;
            shape_bad = (dmem_size_i == 2'd3) || (off >= SPAN) ||
                        ((dmem_addr_i % nbytes) != 0);
            bad = (dmem_wen_i || dmem_ren_i) && (shape_bad || (dmem_wen_i && dmem_ren_i));
            if (dmem_ren_i)
                e_rdata <= bad ? 32'h0 : {m_mem[(off & ~32'd3) + 3], m_mem[(off & ~32'd3) + 2],
                                          m_mem[(off & ~32'd3) + 1], m_mem[off & ~32'd3]};
            if (dmem_wen_i && !shape_bad)
                for (int k = 0; k < nbytes; k++) m_mem[off + k] <= dmem_wdata_i[8*k +: 8];
            if (bad && (!e_err || err_clr_i)) begin
                e_err <= 1'b1; e_err_addr <= dmem_addr_i;
            end else if (err_clr_i) begin
                e_err <= 1'b0; e_err_addr <= '0;
            end
            if (err_clr_i) begin
                e_rd <= '0; e_wr <= '0;
            end else begin
                e_rd <= e_rd + 32'(dmem_ren_i && !bad);
                e_wr <= e_wr + 32'(dmem_wen_i && !bad);
            end
        end
    end

    always @(negedge clock) begin
        check("model rdata", dmem_rdata_o, e_rdata);
        check("model err", 32'(err_o), 32'(e_err));
        check("model err_addr", err_addr_o, e_err_addr);
`ifdef RISCV_DMEM_STATS_EN
        check("model rd_count", rd_count_o, e_rd);
        check("model wr_count", wr_count_o, e_wr);
`endif
    end

    // One access cycle: drive, let the edge happen, return 1 time unit later.
    task automatic cyc(input logic wen, input logic ren, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
        dmem_wen_i = wen; dmem_ren_i = ren; dmem_size_i = size;
        dmem_addr_i = addr; dmem_wdata_i = wdata; err_clr_i = clr;
        @(posedge clock);
        #1;
        dmem_wen_i = 1'b0; dmem_ren_i = 1'b0; err_clr_i = 1'b0;
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        cyc(1'b1, 1'b0, size, addr, wdata, 1'b0);
    endtask

    task automatic ld(input logic [1:0] size, input logic [31:0] addr);
        cyc(1'b0, 1'b1, size, addr, 32'h0, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; dmem_wen_i = 1'b0; dmem_ren_i = 1'b0; dmem_size_i = 2'b10;
        dmem_addr_i = '0; dmem_wdata_i = '0; err_clr_i = 1'b0;
        #3;
        check("reset rdata", dmem_rdata_o, 32'h0);
        check("reset err", 32'(err_o), 32'h0);
        check("reset err_addr", err_addr_o, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
        check("idle rdata", dmem_rdata_o, 32'h0);
        check("idle err", 32'(err_o), 32'h0);

        st(2'b10, 32'h10, 32'hDEADBEEF);
        ld(2'b10, 32'h10);
        check("word roundtrip", dmem_rdata_o, 32'hDEADBEEF);
        check("word roundtrip err", 32'(err_o), 32'h0);

        st(2'b10, 32'h20, 32'h0);
        st(2'b00, 32'h22, 32'h0000_00A5);
        st(2'b01, 32'h20, 32'h0000_1234);
        ld(2'b10, 32'h20);
        check("byte/half lanes", dmem_rdata_o, 32'h00A5_1234);
        st(2'b01, 32'h22, 32'h0000_BEEF);
        ld(2'b10, 32'h20);
        check("upper half lane", dmem_rdata_o, 32'hBEEF_1234);

        st(2'b10, 32'h24, 32'hCAFEF00D);
        st(2'b10, 32'h26, 32'h0000_0001);
        check("misaligned err", 32'(err_o), 32'h1);
        check("misaligned err_addr", err_addr_o, 32'h26);
        ld(2'b10, 32'h24);
        check("misaligned no write", dmem_rdata_o, 32'hCAFEF00D);
        ld(2'b01, 32'h31);
        check("second err keeps addr", err_addr_o, 32'h26);
        check("errored load rdata", dmem_rdata_o, 32'h0);
        clr();
        check("clear err", 32'(err_o), 32'h0);
        check("clear err_addr", err_addr_o, 32'h0);

        ld(2'b10, 32'h10);
        ld(2'b10, BASE_ADDR + SPAN);
        check("oor rdata", dmem_rdata_o, 32'h0);
        check("oor err", 32'(err_o), 32'h1);
        check("oor err_addr", err_addr_o, BASE_ADDR + SPAN);
        clr();
        st(2'b11, 32'h10, 32'hFFFF_FFFF);
        check("illegal size err", 32'(err_o), 32'h1);
        ld(2'b10, 32'h10);
        check("illegal size no write", dmem_rdata_o, 32'hDEADBEEF);

        cyc(1'b0, 1'b1, 2'b10, 32'h41, 32'h0, 1'b1);
        check("clr+err new wins", err_addr_o, 32'h41);
        check("clr+err flag", 32'(err_o), 32'h1);
        clr();

        ld(2'b10, 32'h10);
        cyc(1'b1, 1'b1, 2'b10, 32'h30, 32'h55AA_55AA, 1'b0);
        check("wen+ren rdata", dmem_rdata_o, 32'h0);
        check("wen+ren err", 32'(err_o), 32'h1);
        clr();
        ld(2'b10, 32'h30);
        check("wen+ren write commits", dmem_rdata_o, 32'h55AA_55AA);
        cyc(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
        check("rdata holds", dmem_rdata_o, 32'h55AA_55AA);

        st(2'b10, 32'h44, 32'h1);
        @(negedge clock); #2 reset_n = 1'b0;
        #1;
        check("async reset rdata", dmem_rdata_o, 32'h0);
        check("async reset err", 32'(err_o), 32'h0);
        @(posedge clock); @(negedge clock); reset_n = 1'b1;

        st(2'b10, 32'h40, 32'h1111_1111);
        st(2'b10, 32'h44, 32'h2222_2222);
        st(2'b10, 32'h48, 32'h3333_3333);
        ld(2'b10, 32'h40);
        ld(2'b10, 32'h44);
        check("post-reset load", dmem_rdata_o, 32'h2222_2222);
        ld(2'b10, 32'h42);
`ifdef RISCV_DMEM_STATS_EN
        check("stats wr_count", wr_count_o, 32'd3);
        check("stats rd_count", rd_count_o, 32'd2);
`endif
        check("stats misaligned err", 32'(err_o), 32'h1);

        @(negedge clock); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
